div_seq_ctrl: RTL

- Multi-cycle sequencer for DIV/DIVU issued from the execute stage.
- Runs a 32-step restoring shift-subtract division over latched operands.
- Raises a stall request so the pipeline controller freezes the front of the pipe while the division runs.
- Delivers a 64-bit {remainder, quotient} result that EX forwards toward HI/LO.

---
 rtl/div_seq_ctrl_pkg.sv | 30 +++
 rtl/div_seq_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl_pkg
// Description : Shared state encodings and control constants for the divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic c_div_start    = 1'b1;
  localparam logic c_div_stop     = 1'b0;
  localparam logic c_div_ready    = 1'b1;
  localparam logic c_div_notready = 1'b0;

  // Result bus bounds as seen by EX when forwarding toward HI/LO.
  localparam int c_divbus_msb = 63;
  localparam int c_divbus_lsb = 0;

  // ALU op codes that EX decodes into start_i / signed_i.
  localparam logic [7:0] c_exe_div_op  = 8'b0001_1010;
  localparam logic [7:0] c_exe_divu_op = 8'b0001_1011;

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Multi-cycle restoring DIV/DIVU sequencer with pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  div_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [2*WIDTH:0]   r_work, w_work_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
  logic               r_sign_q, w_sign_q_nxt;
  logic               r_sign_r, w_sign_r_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic               w_op1_neg, w_op2_neg;
  logic [WIDTH-1:0]   w_op1_abs, w_op2_abs;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign w_op1_neg = signed_i & opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_i & opdata2_i[WIDTH-1];
  assign w_op1_abs = w_op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_op2_abs = w_op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // Working register: [2W:W+1] partial remainder, low bits dividend/quotient.
  assign w_trial = r_work[2*WIDTH:WIDTH] - {1'b0, r_divisor};
  assign w_quot  = r_sign_q ? (~r_work[WIDTH-1:0] + 1'b1) : r_work[WIDTH-1:0];
  assign w_rem   = r_sign_r ? (~r_work[2*WIDTH:WIDTH+1] + 1'b1)
                            : r_work[2*WIDTH:WIDTH+1];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_sign_q_nxt  = r_sign_q;
    w_sign_r_nxt  = r_sign_r;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    case (r_state)
      DIV_FREE: begin
        if (start_i == c_div_start && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_divisor_nxt = w_op2_abs;
            w_sign_q_nxt  = w_op1_neg ^ w_op2_neg;
            w_sign_r_nxt  = w_op1_neg;
            w_work_nxt    = {{WIDTH{1'b0}}, w_op1_abs, 1'b0};
            w_cnt_nxt     = '0;
          end
        end
      end
      DIV_BYZERO: begin
        w_state_nxt  = DIV_END;
        w_result_nxt = '0;
        w_ready_nxt  = c_div_ready;
      end
      DIV_ON: begin
        // Dropping start_i mid-division is treated the same as an annul.
        if (annul_i || start_i != c_div_start) begin
          w_state_nxt = DIV_FREE;
          w_ready_nxt = c_div_notready;
        end else if (r_cnt == CNT_W'(WIDTH)) begin
          w_state_nxt  = DIV_END;
          w_result_nxt = {w_rem, w_quot};
          w_ready_nxt  = c_div_ready;
        end else begin
          if (w_trial[WIDTH])
            w_work_nxt = {r_work[2*WIDTH-1:0], 1'b0};
          else
            w_work_nxt = {w_trial[WIDTH-1:0], r_work[WIDTH-1:0], 1'b1};
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DIV_END: begin
        if (start_i != c_div_start) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = c_div_notready;
          w_result_nxt = '0;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_result  <= '0;
      r_ready   <= c_div_notready;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_sign_q  <= w_sign_q_nxt;
      r_sign_r  <= w_sign_r_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = !rst && (start_i == c_div_start) && !r_ready;

endmodule
`default_nettype wire
